// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op codes, default
// busy-window lengths and the behavioural arithmetic used to form HI/LO.
package mul_div_unit_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // Result of one mult/div; valid=0 means HI/LO must be left untouched.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } md_result_t;

  function automatic logic is_md_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic md_result_t md_compute(input logic [3:0]        op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    md_result_t               r;
    logic [2*DATA_W-1:0]      prod;
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    r    = '0;
    prod = '0;
    sa   = $signed(a);
    sb   = $signed(b);
    case (op)
      MDU_MULT: begin
        prod    = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
        r.valid = 1'b1;
        r.hi    = prod[2*DATA_W-1:DATA_W];
        r.lo    = prod[DATA_W-1:0];
      end
      MDU_MULTU: begin
        prod    = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        r.valid = 1'b1;
        r.hi    = prod[2*DATA_W-1:DATA_W];
        r.lo    = prod[DATA_W-1:0];
      end
      MDU_DIV: begin
        if (b != '0) begin
          r.valid = 1'b1;
          // Most-negative / -1 overflows; pin it to the architectural answer.
          if ((a == {1'b1, {(DATA_W-1){1'b0}}}) && (b == '1)) begin
            r.lo = a;
            r.hi = '0;
          end else begin
            r.lo = DATA_W'(sa / sb);
            r.hi = DATA_W'(sa % sb);
          end
        end
      end
      MDU_DIVU: begin
        if (b != '0) begin
          r.valid = 1'b1;
          r.lo    = a / b;
          r.hi    = a % b;
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multiply/divide unit: holds HI/LO, runs mult/div with a fixed busy window
// and applies mthi/mtlo writes in one cycle while idle.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        mdu_op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              req,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_n_q, hi_n_d;
  logic [DATA_W-1:0] lo_n_q, lo_n_d;
  logic              upd_q, upd_d;
  md_result_t        res;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_n_q  <= '0;
      lo_n_q  <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
      upd_q   <= upd_d;
    end
  end

  // Next state: accept work only in IDLE without a flush; BUSY always completes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_n_d  = hi_n_q;
    lo_n_d  = lo_n_q;
    upd_d   = upd_q;
    res     = md_compute(mdu_op, rs_data, rt_data);
    case (state_q)
      ST_IDLE: begin
        if (!req) begin
          if (start && is_md_op(mdu_op)) begin
            hi_n_d  = res.hi;
            lo_n_d  = res.lo;
            upd_d   = res.valid;
            cnt_d   = ((mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU)) ?
                      CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            state_d = ST_BUSY;
            busy_d  = 1'b1;
          end
          if (mdu_op == MDU_MTHI) hi_d = rs_data;
          if (mdu_op == MDU_MTLO) lo_d = rs_data;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (upd_q) begin
            hi_d = hi_n_q;
            lo_d = lo_n_q;
          end
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random traffic
// compared every cycle against an arithmetic model of HI/LO and the busy window.
module tb_mul_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;
  localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2,
                         OP_DIV = 4'd3, OP_DIVU = 4'd4, OP_MTHI = 4'd5, OP_MTLO = 4'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mdu_op = 4'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        req = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .rs_data(rs_data), .rt_data(rt_data), .req(req),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: architectural HI/LO, remaining busy cycles, pending result.
  logic [31:0] m_hi = '0, m_lo = '0, m_ph = '0, m_pl = '0;
  logic        m_upd = 1'b0;
  int          m_rem = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          la, lb, qa, q, r;
    longint unsigned ua, ub, up;
    logic [63:0]     p;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    m_upd = 1'b1;
    if (op == OP_MULT) begin
      p = 64'(la * lb);
      m_ph = p[63:32]; m_pl = p[31:0];
    end else if (op == OP_MULTU) begin
      up = ua * ub; p = 64'(up);
      m_ph = p[63:32]; m_pl = p[31:0];
    end else if (b == 32'd0) begin
      m_upd = 1'b0;
    end else if (op == OP_DIVU) begin
      m_pl = 32'(ua / ub); m_ph = 32'(ua % ub);
    end else begin
      qa = ((la < 0) ? -la : la) / ((lb < 0) ? -lb : lb);
      q  = ((la < 0) != (lb < 0)) ? -qa : qa;
      r  = la - q * lb;
      m_pl = 32'(q); m_ph = 32'(r);
    end
  endtask

  task automatic model_step();
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_upd) begin
        m_hi = m_ph; m_lo = m_pl;
      end
    end else if (!req) begin
      if (start && mdu_op >= OP_MULT && mdu_op <= OP_DIVU) begin
        model_compute(mdu_op, rs_data, rt_data);
        m_rem = (mdu_op <= OP_MULTU) ? MC : DC;
      end
      if (mdu_op == OP_MTHI) m_hi = rs_data;
      if (mdu_op == OP_MTLO) m_lo = rs_data;
    end
  endtask

  // One clock: drive inputs, step model at the edge, compare on the falling edge.
  task automatic cycle(input logic st, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rq);
    start = st; mdu_op = op; rs_data = a; rt_data = b; req = rq;
    if (st) check("start_while_busy", 32'(busy), 32'd0);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("busy", 32'(busy), 32'(m_rem > 0));
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  endtask

  task automatic idle();
    cycle(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
  endtask

  // Run idle cycles while busy is high; returns number of busy cycles observed.
  task automatic drain(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      idle();
    end
    if (busy) check("drain_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    cycle(1'b1, op, a, b, 1'b0);
    drain(n);
    check({tag, "_cycles"}, 32'(n), 32'(exp_n));
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [3:0] op;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle();

    run_op("mult",  OP_MULT,  32'hFFFF_FFFE, 32'd3, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, MC, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div",   OP_DIV,   32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",  OP_DIVU,  32'd7,         32'd2, DC, 32'd1,         32'd3);

    cycle(1'b0, OP_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", 32'(busy), 32'd0);
    cycle(1'b0, OP_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b1);
    check("mtlo_req_lo", lo, 32'd3);

    cycle(1'b0, OP_MTLO, 32'h0000_00AA, 32'd0, 1'b0);
    run_op("div0", OP_DIV, 32'd5, 32'd0, DC, 32'h1234_5678, 32'h0000_00AA);
    run_op("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000);

    cycle(1'b1, OP_DIV, 32'd9, 32'd3, 1'b1);
    check("req_start_busy", 32'(busy), 32'd0);
    idle();
    check("req_start_busy2", 32'(busy), 32'd0);

    // Asynchronous reset part way through a divide.
    cycle(1'b1, OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (3) idle();
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_hi", hi, 32'd0);
    check("async_rst_lo", lo, 32'd0);
    m_hi = '0; m_lo = '0; m_ph = '0; m_pl = '0; m_upd = 1'b0; m_rem = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (DC + 2) idle();
    check("no_completion_lo", lo, 32'd0);

    // Random traffic; starts and mt writes only while the model is idle.
    for (int i = 0; i < 400; i++) begin
      if (m_rem > 0) begin
        cycle(1'b0, OP_NONE, $urandom, $urandom, 1'($urandom_range(0, 1)));
      end else begin
        op = 4'($urandom_range(0, 7));
        cycle(1'($urandom_range(0, 3) != 0), op, rand_operand(), rand_operand(),
              1'($urandom_range(0, 7) == 0));
      end
    end
    drain(n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
